// File: rtl/abstract_cmd_ctrl.sv
// abstract_cmd_ctrl: sequencing controller for Debug Module abstract commands.
// Accepts a DMI command word, validates it, runs the register-access handshake
// and optionally the program-buffer execution handshake, and owns
// abstractcs.busy plus the sticky abstractcs.cmderr field (W1C).
// Optional feature macro: ABSTRACT_CMD_TIMEOUT_EN (per-state watchdog that
// aborts XFER/EXEC after TimeoutCycles cycles with cmderr = 7).
module abstract_cmd_ctrl #(
    parameter int TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_i,
    input  logic        unsupported_i,
    input  logic        hart_halted_i,
    input  logic        cmderr_clr_valid_i,
    input  logic [2:0]  cmderr_clr_i,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    output logic        acc_req_o,
    output logic        acc_write_o,
    output logic [15:0] acc_regno_o,
    output logic [2:0]  acc_size_o,
    input  logic        acc_ack_i,
    input  logic        acc_err_i,
    output logic        exec_req_o,
    input  logic        exec_done_i,
    input  logic        exec_exception_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // cmderr encodings
    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_BUSY  = 3'd1;
    localparam logic [2:0] ERR_NOSUP = 3'd2;
    localparam logic [2:0] ERR_EXC   = 3'd3;
    localparam logic [2:0] ERR_HALT  = 3'd4;
`ifdef ABSTRACT_CMD_TIMEOUT_EN
    localparam logic [2:0] ERR_TMO   = 3'd7;
    localparam int         TmoW      = $clog2(TimeoutCycles + 1);
`endif

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic        acc_req_q, acc_req_d;
    logic        exec_req_q, exec_req_d;
    logic        acc_write_q, acc_write_d;
    logic [15:0] acc_regno_q, acc_regno_d;
    logic [2:0]  acc_size_q, acc_size_d;
    logic        postexec_q, postexec_d;
    logic        err_set_s;
    logic [2:0]  err_code_s;
    logic        tmo_expired_s;

`ifdef ABSTRACT_CMD_TIMEOUT_EN
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog: flags the last permitted cycle of XFER/EXEC, restarts on state entry
    always_comb begin
        tmo_expired_s = (tmo_cnt_q == TmoW'(TimeoutCycles - 1));
        if ((state_d != state_q) || ((state_d != ST_XFER) && (state_d != ST_EXEC))) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
    end
`else
    // Without the watchdog the controller waits indefinitely for ack/done
    always_comb begin
        tmo_expired_s = 1'b0;
    end
`endif

    // Next-state, error-source selection and latched command fields
    always_comb begin
        state_d     = state_q;
        acc_write_d = acc_write_q;
        acc_regno_d = acc_regno_q;
        acc_size_d  = acc_size_q;
        postexec_d  = postexec_q;
        err_set_s   = 1'b0;
        err_code_s  = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && (cmderr_q == ERR_NONE)) begin
                    if (unsupported_i) begin
                        err_set_s  = 1'b1;
                        err_code_s = ERR_NOSUP;
                    end else if (!hart_halted_i) begin
                        err_set_s  = 1'b1;
                        err_code_s = ERR_HALT;
                    end else begin
                        acc_write_d = cmd_i[16];
                        acc_regno_d = cmd_i[15:0];
                        acc_size_d  = cmd_i[22:20];
                        postexec_d  = cmd_i[18];
                        if (cmd_i[17]) begin
                            state_d = ST_XFER;
                        end else if (cmd_i[18]) begin
                            state_d = ST_EXEC;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                // A response in the expiry cycle takes precedence over the timeout
                if (acc_ack_i) begin
                    if (acc_err_i) begin
                        err_set_s  = 1'b1;
                        err_code_s = ERR_EXC;
                        state_d    = ST_DONE;
                    end else if (postexec_q) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (tmo_expired_s) begin
`ifdef ABSTRACT_CMD_TIMEOUT_EN
                    err_set_s  = 1'b1;
                    err_code_s = ERR_TMO;
`endif
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_EXEC: begin
                if (exec_done_i) begin
                    if (exec_exception_i) begin
                        err_set_s  = 1'b1;
                        err_code_s = ERR_EXC;
                    end else begin
                        err_set_s = 1'b0;
                    end
                    state_d = ST_DONE;
                end else if (tmo_expired_s) begin
`ifdef ABSTRACT_CMD_TIMEOUT_EN
                    err_set_s  = 1'b1;
                    err_code_s = ERR_TMO;
`endif
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A command arriving mid-sequence is dropped and reported as busy,
        // unless the in-flight sequence already raised its own error this cycle
        if (cmd_valid_i && (state_q != ST_IDLE) && !err_set_s) begin
            err_set_s  = 1'b1;
            err_code_s = ERR_BUSY;
        end else begin
            err_set_s  = err_set_s;
        end
    end

    // cmderr update: first error wins; an allowed set discards a same-cycle clear
    always_comb begin
        if (err_set_s && (cmderr_q == ERR_NONE)) begin
            cmderr_d = err_code_s;
        end else if (cmderr_clr_valid_i) begin
            cmderr_d = cmderr_q & ~cmderr_clr_i;
        end else begin
            cmderr_d = cmderr_q;
        end
    end

    // Registered status and handshake outputs derived from the next state
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        acc_req_d  = (state_d == ST_XFER);
        exec_req_d = (state_d == ST_EXEC);
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cmderr_q    <= 3'd0;
            acc_req_q   <= 1'b0;
            exec_req_q  <= 1'b0;
            acc_write_q <= 1'b0;
            acc_regno_q <= 16'd0;
            acc_size_q  <= 3'd0;
            postexec_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            cmderr_q    <= cmderr_d;
            acc_req_q   <= acc_req_d;
            exec_req_q  <= exec_req_d;
            acc_write_q <= acc_write_d;
            acc_regno_q <= acc_regno_d;
            acc_size_q  <= acc_size_d;
            postexec_q  <= postexec_d;
        end
    end

`ifdef ABSTRACT_CMD_TIMEOUT_EN
    // Watchdog counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign busy_o      = busy_q;
    assign cmderr_o    = cmderr_q;
    assign acc_req_o   = acc_req_q;
    assign exec_req_o  = exec_req_q;
    assign acc_write_o = acc_write_q;
    assign acc_regno_o = acc_regno_q;
    assign acc_size_o  = acc_size_q;

endmodule

// File: tb/tb_abstract_cmd_ctrl.sv
// Directed testbench for abstract_cmd_ctrl with a scoreboard queue of
// expected values. Define ABSTRACT_CMD_TIMEOUT_EN to also cover the watchdog.
module tb_abstract_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd = 32'd0;
    logic        unsup = 1'b0;
    logic        halted = 1'b1;
    logic        clr_valid = 1'b0;
    logic [2:0]  clr = 3'd0;
    logic        busy_o;
    logic [2:0]  cmderr_o;
    logic        acc_req_o;
    logic        acc_write_o;
    logic [15:0] acc_regno_o;
    logic [2:0]  acc_size_o;
    logic        ack = 1'b0;
    logic        ack_err = 1'b0;
    logic        exec_req_o;
    logic        done = 1'b0;
    logic        exc = 1'b0;

    int errors = 0;
    int checks = 0;
    int n;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    abstract_cmd_ctrl #(.TimeoutCycles(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cmd_valid_i        (cmd_valid),
        .cmd_i              (cmd),
        .unsupported_i      (unsup),
        .hart_halted_i      (halted),
        .cmderr_clr_valid_i (clr_valid),
        .cmderr_clr_i       (clr),
        .busy_o             (busy_o),
        .cmderr_o           (cmderr_o),
        .acc_req_o          (acc_req_o),
        .acc_write_o        (acc_write_o),
        .acc_regno_o        (acc_regno_o),
        .acc_size_o         (acc_size_o),
        .acc_ack_i          (ack),
        .acc_err_i          (ack_err),
        .exec_req_o         (exec_req_o),
        .exec_done_i        (done),
        .exec_exception_i   (exc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=0x%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic issue(input logic [31:0] c, input logic u, input logic h);
        cmd = c;
        unsup = u;
        halted = h;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        unsup = 1'b0;
        halted = 1'b1;
    endtask

    task automatic clear(input logic [2:0] m);
        clr_valid = 1'b1;
        clr = m;
        tick();
        clr_valid = 1'b0;
        clr = 3'd0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        push("rst_busy", 32'd0); push("rst_cmderr", 32'd0); push("rst_req", 32'd0);
        push("rst_exec", 32'd0); push("rst_regno", 32'd0);
        check(busy_o); check(cmderr_o); check(acc_req_o); check(exec_req_o); check(acc_regno_o);
        rst = 1'b0;
        tick();

        // Test 1: plain read access, ack in the fourth request cycle
        push("t1_busy", 32'd1); push("t1_req", 32'd1); push("t1_regno", 32'h1000);
        push("t1_size", 32'd2); push("t1_write", 32'd0);
        issue(32'h0022_1000, 1'b0, 1'b1);
        check(busy_o); check(acc_req_o); check(acc_regno_o); check(acc_size_o); check(acc_write_o);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (acc_req_o) n++;
            if (n == 4) begin
                ack = 1'b1;
                tick();
                ack = 1'b0;
                break;
            end
            tick();
        end
        push("t1_req_cycles", 32'd4); push("t1_done_req", 32'd0); push("t1_done_busy", 32'd1);
        check(n); check(acc_req_o); check(busy_o);
        tick();
        push("t1_idle_busy", 32'd0); push("t1_cmderr", 32'd0);
        check(busy_o); check(cmderr_o);

        // Test 2: transfer + postexec, ack in first request cycle, done after 5 cycles
        push("t2_req", 32'd1); push("t2_regno", 32'h1008);
        issue(32'h0026_1008, 1'b0, 1'b1);
        check(acc_req_o); check(acc_regno_o);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        push("t2_exec", 32'd1); push("t2_req_off", 32'd0); push("t2_busy", 32'd1);
        check(exec_req_o); check(acc_req_o); check(busy_o);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (exec_req_o) n++;
            if (n == 6) begin
                done = 1'b1;
                tick();
                done = 1'b0;
                break;
            end
            tick();
        end
        push("t2_exec_cycles", 32'd6); push("t2_exec_off", 32'd0); push("t2_done_busy", 32'd1);
        check(n); check(exec_req_o); check(busy_o);
        tick();
        push("t2_idle_busy", 32'd0); push("t2_cmderr", 32'd0);
        check(busy_o); check(cmderr_o);

        // No-op command: busy for exactly one cycle, regno latched from the new word
        push("noop_busy", 32'd1); push("noop_req", 32'd0); push("noop_exec", 32'd0); push("noop_regno", 32'h0000);
        issue(32'h0000_0000, 1'b0, 1'b1);
        check(busy_o); check(acc_req_o); check(exec_req_o); check(acc_regno_o);
        tick();
        push("noop_idle", 32'd0);
        check(busy_o);

        // Test 3: unsupported, then ignored command, then full clear
        push("t3_cmderr", 32'd2); push("t3_busy", 32'd0);
        issue(32'h0022_1000, 1'b1, 1'b1);
        check(cmderr_o); check(busy_o);
        push("t3_ign_busy", 32'd0); push("t3_ign_cmderr", 32'd2);
        issue(32'h0022_1000, 1'b0, 1'b1);
        check(busy_o); check(cmderr_o);
        push("t3_clr", 32'd0);
        clear(3'b111);
        check(cmderr_o);

        // Test 4: hart not halted, then access fault skips postexec
        push("t4_cmderr", 32'd4); push("t4_req", 32'd0);
        issue(32'h0022_1000, 1'b0, 1'b0);
        check(cmderr_o); check(acc_req_o);
        clear(3'b111);
        issue(32'h0026_1008, 1'b0, 1'b1);
        ack = 1'b1;
        ack_err = 1'b1;
        tick();
        ack = 1'b0;
        ack_err = 1'b0;
        push("t4_acc_err", 32'd3); push("t4_exec", 32'd0); push("t4_busy", 32'd1);
        check(cmderr_o); check(exec_req_o); check(busy_o);
        tick();
        push("t4_exec_after", 32'd0); push("t4_idle", 32'd0);
        check(exec_req_o); check(busy_o);
        clear(3'b111);

        // Test 5: command while busy, in-flight access continues
        issue(32'h0022_1000, 1'b0, 1'b1);
        push("t5_cmderr", 32'd1); push("t5_req", 32'd1); push("t5_regno", 32'h1000);
        issue(32'h0026_1234, 1'b0, 1'b1);
        check(cmderr_o); check(acc_req_o); check(acc_regno_o);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        push("t5_done_busy", 32'd1); push("t5_no_exec", 32'd0);
        check(busy_o); check(exec_req_o);
        tick();
        push("t5_idle", 32'd0);
        check(busy_o);
        clear(3'b111);

        // Same-cycle set and clear: allowed set wins; blocked set lets clear apply
        clr_valid = 1'b1;
        clr = 3'b001;
        push("t5_setclr", 32'd2);
        issue(32'h0022_1000, 1'b1, 1'b1);
        check(cmderr_o);
        clr_valid = 1'b1;
        clr = 3'b010;
        push("t5_blocked_clr", 32'd0);
        issue(32'h0022_1000, 1'b1, 1'b1);
        clr_valid = 1'b0;
        clr = 3'd0;
        check(cmderr_o);

        // Stray ack/done in IDLE are ignored
        ack = 1'b1;
        done = 1'b1;
        tick();
        ack = 1'b0;
        done = 1'b0;
        push("t6_stray_busy", 32'd0); push("t6_stray_req", 32'd0);
        check(busy_o); check(exec_req_o);

        // Reset mid-XFER clears outputs immediately
        issue(32'h0022_1000, 1'b0, 1'b1);
        push("t6_pre_req", 32'd1);
        check(acc_req_o);
        rst = 1'b1;
        #1;
        push("t6_rst_req", 32'd0); push("t6_rst_busy", 32'd0); push("t6_rst_regno", 32'd0); push("t6_rst_size", 32'd0);
        check(acc_req_o); check(busy_o); check(acc_regno_o); check(acc_size_o);
        tick();
        rst = 1'b0;
        tick();

`ifdef ABSTRACT_CMD_TIMEOUT_EN
        // Watchdog: no ack, abort after 8 request cycles with cmderr 7
        issue(32'h0022_1000, 1'b0, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!acc_req_o) break;
            n++;
            tick();
        end
        push("tmo_cycles", 32'd8); push("tmo_cmderr", 32'd7); push("tmo_busy", 32'd1);
        check(n); check(cmderr_o); check(busy_o);
        tick();
        push("tmo_idle", 32'd0);
        check(busy_o);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
